// File: rtl/ray_length_calc_pkg.sv
// Shared types and constants for the ray length block.
// Q4.12 direction vectors; len carries the same format.
package ray_length_calc_pkg;

  localparam int WIDTH  = 16;
  localparam int Q_BITS = 12;
  localparam int SUM_W  = 2 * WIDTH + 2;
  localparam int ROOT_W = WIDTH + 1;
  localparam int FRAC_W = 2 * Q_BITS;

  localparam logic [WIDTH-1:0] MAX_16 = 16'h7FFF;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } RayDirection;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] len;
  } RayDirection_len;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    SQRT,
    DONE
  } rlc_state_t;

  function automatic logic [WIDTH-1:0] sat_len(
    input logic [ROOT_W-1:0] r
  );
    if (r > ROOT_W'(MAX_16)) sat_len = MAX_16;
    else                     sat_len = r[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ray_length_calc_isqrt_seq.sv
// Restoring digit-by-digit integer square root.
// One root bit per cycle; done pulses after the last bit.
module isqrt_seq #(
  parameter int RW = 34
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [RW-1:0]   radicand,
  output logic [RW/2-1:0] root,
  output logic            done
);

  localparam int RB  = RW / 2;
  localparam int RMW = RB + 1;
  localparam int SHW = RB + 3;
  localparam int CW  = $clog2(RB);

  logic [RW-1:0]  rad;
  logic [RMW-1:0] rem;
  logic [CW-1:0]  cnt;
  logic           busy;

  logic [SHW-1:0] rem_sh;
  logic [SHW-1:0] trial;
  logic [RMW-1:0] rem_nx;
  logic           ge;

  // Trial subtraction for the current root digit.
  always_comb begin
    rem_sh = {rem, rad[RW-1 -: 2]};
    trial  = {1'b0, root, 2'b01};
    ge     = (rem_sh >= trial);
    rem_nx = ge ? RMW'(rem_sh - trial)
                : RMW'(rem_sh);
  end

  // Iteration state: radicand shifter, remainder, root, counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        rad  <= radicand;
        rem  <= '0;
        root <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        rad  <= {rad[RW-3:0], 2'b00};
        rem  <= rem_nx;
        root <= {root[RB-2:0], ge};
        if (cnt == CW'(RB - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ray_length_calc.sv
// Ray direction length: len = sqrt(x^2+y^2+z^2), saturated.
// One ray in flight; result handed to the normaliser.
module ray_length_calc
  import ray_length_calc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  RayDirection     dir_in,
  output logic            ready_out,
  output logic            valid_out,
  output RayDirection_len RDL_out,
  output logic            zero_len
);

  rlc_state_t state;

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] z_r;
  logic             sum_zero;

  logic signed [2*WIDTH-1:0] px;
  logic signed [2*WIDTH-1:0] py;
  logic signed [2*WIDTH-1:0] pz;
  logic [SUM_W-1:0]          sum;

  logic              sq_load;
  logic [ROOT_W-1:0] root;
  logic              sq_done;

  // Signed squares are non-negative, so their top bit is always 0.
  always_comb begin
    px  = $signed(x_r) * $signed(x_r);
    py  = $signed(y_r) * $signed(y_r);
    pz  = $signed(z_r) * $signed(z_r);
    sum = {2'b00, px} + {2'b00, py} + {2'b00, pz};
  end

  assign sq_load = (state == SQUARE);

  isqrt_seq #(
    .RW (SUM_W)
  ) u_isqrt (
    .clk      (clk),
    .reset    (reset),
    .load     (sq_load),
    .radicand (sum),
    .root     (root),
    .done     (sq_done)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      sum_zero  <= 1'b0;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      zero_len  <= 1'b0;
      RDL_out   <= '0;
    end else begin
      valid_out <= 1'b0;
      zero_len  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            x_r       <= dir_in.x;
            y_r       <= dir_in.y;
            z_r       <= dir_in.z;
            ready_out <= 1'b0;
            state     <= SQUARE;
          end
        end
        SQUARE: begin
          sum_zero <= (sum == '0);
          state    <= SQRT;
        end
        SQRT: begin
          if (sq_done) begin
            valid_out   <= 1'b1;
            zero_len    <= sum_zero;
            RDL_out.x   <= x_r;
            RDL_out.y   <= y_r;
            RDL_out.z   <= z_r;
            RDL_out.len <= sat_len(root);
            state       <= DONE;
          end
        end
        DONE: begin
          ready_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_length_calc.sv
// Scoreboard bench for ray_length_calc.
// Directed vectors; monitor checks each valid_out.
module tb_ray_length_calc;
  import ray_length_calc_pkg::*;

  logic            clk;
  logic            reset;
  logic            start;
  RayDirection     dir_in;
  logic            ready_out;
  logic            valid_out;
  RayDirection_len RDL_out;
  logic            zero_len;

  typedef struct {
    RayDirection_len rdl;
    logic            zl;
    int              acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  int   n_valid;
  int   n_push;
  int   cyc;

  ray_length_calc dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir_in    (dir_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .RDL_out   (RDL_out),
    .zero_len  (zero_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented result with the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_out) begin
        n_valid++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(RDL_out), 64'hX);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rdl", RDL_out, e.rdl);
          chk("zero_len", 64'(zero_len), 64'(e.zl));
          chk("latency", 64'(cyc - e.acc), 64'd19);
        end
      end else begin
        chk("zl_idle", 64'(zero_len), 64'd0);
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (ready_out !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (ready_out !== 1'b1)
      chk("ready_timeout", 64'(ready_out), 64'd1);
  endtask

  task automatic issue(input RayDirection d,
                       input logic [15:0] len,
                       input logic zl,
                       input bit expect_out);
    exp_t e;
    wait_ready();
    dir_in = d;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    if (expect_out) begin
      e.rdl = {d.x, d.y, d.z, len};
      e.zl  = zl;
      e.acc = cyc;
      q.push_back(e);
      n_push++;
    end
  endtask

  function automatic RayDirection mk(input logic [15:0] x,
                                     input logic [15:0] y,
                                     input logic [15:0] z);
    RayDirection d;
    d.x = x;
    d.y = y;
    d.z = z;
    return d;
  endfunction

  initial begin
    exp_t e;
    int t;
    n_cmp = 0; n_bad = 0; n_valid = 0; n_push = 0; cyc = 0;
    reset  = 1'b0;
    start  = 1'b0;
    dir_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_zl", 64'(zero_len), 64'd0);
    chk("rst_rdl", RDL_out, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(mk(16'h3000, 16'h4000, 16'h0000), 16'h5000, 1'b0, 1);
    chk("busy_ready", 64'(ready_out), 64'd0);
    issue(mk(16'hF000, 16'h0000, 16'h0000), 16'h1000, 1'b0, 1);
    issue(mk(16'h1000, 16'h1000, 16'h1000), 16'h1BB6, 1'b0, 1);
    issue(mk(16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h7FFF, 1'b0, 1);
    issue(mk(16'h8000, 16'h8000, 16'h8000), 16'h7FFF, 1'b0, 1);
    issue(mk(16'h0000, 16'h0000, 16'h0000), 16'h0000, 1'b1, 1);
    issue(mk(16'h0000, 16'h0000, 16'hFFFF), 16'h0001, 1'b0, 1);
    issue(mk(16'h0000, 16'h0800, 16'h0000), 16'h0800, 1'b0, 1);
    wait_ready();
    repeat (3) @(negedge clk);
    chk("hold_rdl", RDL_out, {16'h0, 16'h0800, 16'h0, 16'h0800});

    issue(mk(16'h0000, 16'h3000, 16'h4000), 16'h5000, 1'b0, 1);
    repeat (4) @(negedge clk);
    dir_in = mk(16'h1000, 16'h0000, 16'h0000);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("ignored_ready", 64'(ready_out), 64'd0);

    issue(mk(16'h1000, 16'h2000, 16'h3000), 16'h0000, 1'b0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", 64'(ready_out), 64'd1);
    chk("abort_valid", 64'(valid_out), 64'd0);
    chk("abort_rdl", RDL_out, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_abort_ready", 64'(ready_out), 64'd1);

    issue(mk(16'h4000, 16'h0000, 16'h3000), 16'h5000, 1'b0, 1);
    dir_in = mk(16'hF000, 16'hF000, 16'hF000);
    start  = 1'b1;
    wait_ready();
    e.rdl = {16'hF000, 16'hF000, 16'hF000, 16'h1BB6};
    e.zl  = 1'b0;
    e.acc = cyc + 1;
    q.push_back(e);
    n_push++;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accept", 64'(ready_out), 64'd0);

    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("valid_count", 64'(n_valid), 64'(n_push));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
